// File: rtl/reg_file_pkg.sv
// Shared sizing and flag layout for the register file and its flag register.
package reg_file_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NREGS    = 4;
    localparam int unsigned AW       = $clog2(NREGS);
    localparam int unsigned WCOUNT_W = 8;
    localparam int unsigned FLAGS_W  = 3;

    localparam int unsigned Z_BIT = 2;
    localparam int unsigned N_BIT = 1;
    localparam int unsigned C_BIT = 0;

    typedef logic [FLAGS_W-1:0]  flags_t;
    typedef logic [WCOUNT_W-1:0] wcount_t;

endpackage

// File: rtl/reg_file_if.sv
// Write/read/flag bundle between the datapath (master) and the register file (slave).
interface reg_file_if #(
    parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
    parameter int unsigned AW     = reg_file_pkg::AW
);

    logic                            we;
    logic [AW-1:0]                   waddr;
    logic [DATA_W-1:0]               wdata;
    logic                            flag_we;
    logic                            cin;
    logic [AW-1:0]                   raddr_a;
    logic [AW-1:0]                   raddr_b;
    logic [DATA_W-1:0]               rdata_a;
    logic [DATA_W-1:0]               rdata_b;
    logic [reg_file_pkg::FLAGS_W-1:0]  flags;
    logic [reg_file_pkg::WCOUNT_W-1:0] wcount;

    modport master (
        output we, waddr, wdata, flag_we, cin, raddr_a, raddr_b,
        input  rdata_a, rdata_b, flags, wcount
    );

    modport slave (
        input  we, waddr, wdata, flag_we, cin, raddr_a, raddr_b,
        output rdata_a, rdata_b, flags, wcount
    );

endinterface

// File: rtl/reg_file_flag_reg.sv
// Z/N/C flag register, loaded from the ALU result independently of the register write.
module flag_reg #(
    parameter int unsigned DATA_W = reg_file_pkg::DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flag_we,
    input  logic [DATA_W-1:0]                wdata,
    input  logic                             cin,
    output logic [reg_file_pkg::FLAGS_W-1:0] flags
);
    import reg_file_pkg::*;

    flags_t flags_d, flags_q;

    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d[Z_BIT] = (wdata == '0);
            flags_d[N_BIT] = wdata[DATA_W-1];
            flags_d[C_BIT] = cin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with a write counter and Z/N/C flag register.
module reg_file #(
    parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
    parameter int unsigned NREGS  = reg_file_pkg::NREGS
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    import reg_file_pkg::*;

    localparam int unsigned AddrW = $clog2(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    wcount_t           wcount_q;

    // Reset wins over a write on the same edge, so no partial update survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (bus.we && (bus.waddr == AddrW'(i))) begin
                    regs_q[i] <= bus.wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_q <= '0;
        end else if (bus.we) begin
            wcount_q <= wcount_q + 1'b1;
        end
    end

    // Reads come straight from storage; a same-edge write is not forwarded.
    assign bus.rdata_a = regs_q[bus.raddr_a];
    assign bus.rdata_b = regs_q[bus.raddr_b];
    assign bus.wcount  = wcount_q;

    flag_reg #(
        .DATA_W (DATA_W)
    ) u_flag_reg (
        .clk     (clk),
        .rst     (rst),
        .flag_we (bus.flag_we),
        .wdata   (bus.wdata),
        .cin     (bus.cin),
        .flags   (bus.flags)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file against an array-based reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;

    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference state
    logic [DATA_W-1:0] m_regs [NREGS];
    logic [2:0]        m_flags;
    int                m_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic we, input int wa, input logic [7:0] wd,
                              input logic fwe, input logic ci);
        if (r) begin
            for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
            m_flags = 3'b000;
            m_count = 0;
        end else begin
            if (we) begin
                m_regs[wa] = wd;
                m_count    = (m_count + 1) % 256;
            end
            if (fwe) begin
                m_flags[2] = (wd == 8'h00);
                m_flags[1] = wd[7];
                m_flags[0] = ci;
            end
        end
    endtask

    // Drive one cycle, check pre-edge outputs against the model, then advance model over the edge.
    task automatic cycle(input logic r, input logic we, input int wa, input logic [7:0] wd,
                         input logic fwe, input logic ci, input int ra, input int rb);
        rst         = r;
        bus.we      = we;
        bus.waddr   = wa[AW-1:0];
        bus.wdata   = wd;
        bus.flag_we = fwe;
        bus.cin     = ci;
        bus.raddr_a = ra[AW-1:0];
        bus.raddr_b = rb[AW-1:0];
        #1;
        check_eq("rdata_a", {24'b0, bus.rdata_a}, {24'b0, m_regs[ra]});
        check_eq("rdata_b", {24'b0, bus.rdata_b}, {24'b0, m_regs[rb]});
        check_eq("flags", {29'b0, bus.flags}, {29'b0, m_flags});
        check_eq("wcount", {24'b0, bus.wcount}, m_count);
        @(posedge clk);
        model_edge(r, we, wa, wd, fwe, ci);
        #1;
    endtask

    task automatic peek(input int ra, input int rb);
        bus.raddr_a = ra[AW-1:0];
        bus.raddr_b = rb[AW-1:0];
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.flag_we = 1'b0;
        bus.cin = 1'b0; bus.raddr_a = '0; bus.raddr_b = '0;
        for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
        m_flags = 3'b000;
        m_count = 0;
        @(posedge clk);
        #1;

        // Reset, then every index reads zero.
        cycle(1'b1, 1'b1, 1, 8'h77, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < int'(NREGS); i++) cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, i, i);
        check_eq("rst_flags", {29'b0, bus.flags}, 32'h0);
        check_eq("rst_wcount", {24'b0, bus.wcount}, 32'h0);

        // Write then read: old value in the write cycle, new value after.
        cycle(1'b0, 1'b1, 2, 8'hA5, 1'b0, 1'b0, 2, 2);
        peek(2, 0);
        check_eq("wr_new", {24'b0, bus.rdata_a}, 32'hA5);
        check_eq("wr_count", {24'b0, bus.wcount}, 32'h1);

        // Flag-only updates.
        cycle(1'b0, 1'b0, 2, 8'h00, 1'b1, 1'b1, 2, 0);
        peek(2, 0);
        check_eq("flags_z_c", {29'b0, bus.flags}, 32'b101);
        check_eq("flags_noreg", {24'b0, bus.rdata_a}, 32'hA5);
        cycle(1'b0, 1'b0, 0, 8'h80, 1'b1, 1'b0, 0, 0);
        check_eq("flags_n", {29'b0, bus.flags}, 32'b010);

        // Dual read, distinct and shared.
        cycle(1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 3, 8'hFF, 1'b0, 1'b0, 0, 0);
        peek(1, 3);
        check_eq("dual_a", {24'b0, bus.rdata_a}, 32'h3C);
        check_eq("dual_b", {24'b0, bus.rdata_b}, 32'hFF);
        peek(3, 3);
        check_eq("same_a", {24'b0, bus.rdata_a}, 32'hFF);
        check_eq("same_b", {24'b0, bus.rdata_b}, 32'hFF);

        // Counter wrap after 256 writes from reset.
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 255; i++)
            cycle(1'b0, 1'b1, i % 4, 8'($urandom), 1'b0, 1'b0, 0, 1);
        check_eq("count_255", {24'b0, bus.wcount}, 32'd255);
        cycle(1'b0, 1'b1, 0, 8'h11, 1'b0, 1'b0, 0, 1);
        check_eq("count_wrap", {24'b0, bus.wcount}, 32'd0);

        // Write coinciding with reset is discarded.
        cycle(1'b0, 1'b1, 2, 8'h42, 1'b0, 1'b0, 2, 2);
        cycle(1'b1, 1'b1, 2, 8'h5A, 1'b1, 1'b1, 2, 2);
        peek(2, 2);
        check_eq("rst_override", {24'b0, bus.rdata_a}, 32'h00);
        check_eq("rst_ovr_cnt", {24'b0, bus.wcount}, 32'h0);

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(0, 63) == 0), 1'($urandom), int'($urandom_range(0, NREGS - 1)),
                  8'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
